// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, defaults and range helper for the data-memory arbiter
package dmem_pkg;

  localparam logic [31:0] DMEM_BASE_DEFAULT = 32'h8000_0000;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } mem_rsp_t;

  // Unsigned wrap on the subtraction makes addresses below the base fail too.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input int unsigned size_pow2);
    logic [31:0] off;
    off = addr - base;
    if (size_pow2 >= 32) return 1'b1;
    return (off >> size_pow2) == 32'd0;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - two requester ports plus the single-port memory bus
interface dmem_arbiter_if;

  logic        p0_valid;
  logic        p0_ready;
  logic        p0_we;
  logic [3:0]  p0_be;
  logic [31:0] p0_addr;
  logic [31:0] p0_wdata;
  logic        p0_rsp_valid;
  logic        p0_rsp_err;
  logic [31:0] p0_rdata;

  logic        p1_valid;
  logic        p1_ready;
  logic        p1_we;
  logic [3:0]  p1_be;
  logic [31:0] p1_addr;
  logic [31:0] p1_wdata;
  logic        p1_rsp_valid;
  logic        p1_rsp_err;
  logic [31:0] p1_rdata;

  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  p0_valid, p0_we, p0_be, p0_addr, p0_wdata,
    output p0_ready, p0_rsp_valid, p0_rsp_err, p0_rdata,
    input  p1_valid, p1_we, p1_be, p1_addr, p1_wdata,
    output p1_ready, p1_rsp_valid, p1_rsp_err, p1_rdata,
    output mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output p0_valid, p0_we, p0_be, p0_addr, p0_wdata,
    input  p0_ready, p0_rsp_valid, p0_rsp_err, p0_rdata,
    output p1_valid, p1_we, p1_be, p1_addr, p1_wdata,
    input  p1_ready, p1_rsp_valid, p1_rsp_err, p1_rdata,
    input  mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_starve_ctr.sv
// rtl/dmem_starve_ctr.sv - saturating stall counter that forces a port-1 win
module dmem_starve_ctr #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic p1_valid,
  input  logic p1_grant,
  output logic force_p1
);

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  logic [3:0] starve_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!p1_valid || p1_grant) begin
      starve_cnt <= '0;
    end else if (starve_cnt != MAX_W) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign force_p1 = (starve_cnt == MAX_W);

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - port-0-priority arbiter for the single-port data memory
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned SIZE_POW2 = 9,
  parameter logic [31:0] BASE_ADDR = DMEM_BASE_DEFAULT,
  parameter int unsigned MAX_WAIT  = 4
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  mem_req_t    req0;
  mem_req_t    req1;
  mem_req_t    sel;
  mem_rsp_t    rsp0;
  mem_rsp_t    rsp1;
  logic        grant0;
  logic        grant1;
  logic        force_p1;
  logic        sel_in_range;
  logic [31:0] rdata_next;

  assign req0 = '{we: bus.p0_we, be: bus.p0_be, addr: bus.p0_addr, wdata: bus.p0_wdata};
  assign req1 = '{we: bus.p1_we, be: bus.p1_be, addr: bus.p1_addr, wdata: bus.p1_wdata};

  dmem_starve_ctr #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clk      (clk),
    .rst      (rst),
    .p1_valid (bus.p1_valid),
    .p1_grant (grant1),
    .force_p1 (force_p1)
  );

  always_comb begin
    grant0 = bus.p0_valid && !(bus.p1_valid && force_p1);
    grant1 = bus.p1_valid && !grant0;
  end

  // The idle bus parks on port 0 so its address is already presented.
  assign sel          = grant1 ? req1 : req0;
  assign sel_in_range = addr_in_range(sel.addr, BASE_ADDR, SIZE_POW2);
  assign rdata_next   = (!sel.we && sel_in_range) ? bus.mem_rdata : 32'd0;

  assign bus.p0_ready  = grant0;
  assign bus.p1_ready  = grant1;
  assign bus.mem_we    = !rst && (grant0 || grant1) && sel.we && sel_in_range;
  assign bus.mem_be    = sel.be;
  assign bus.mem_addr  = sel.addr;
  assign bus.mem_wdata = sel.wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp0 <= '0;
      rsp1 <= '0;
    end else begin
      rsp0 <= '{valid: grant0, err: grant0 && !sel_in_range,
                rdata: grant0 ? rdata_next : 32'd0};
      rsp1 <= '{valid: grant1, err: grant1 && !sel_in_range,
                rdata: grant1 ? rdata_next : 32'd0};
    end
  end

  assign bus.p0_rsp_valid = rsp0.valid;
  assign bus.p0_rsp_err   = rsp0.err;
  assign bus.p0_rdata     = rsp0.rdata;
  assign bus.p1_rsp_valid = rsp1.valid;
  assign bus.p1_rsp_err   = rsp1.err;
  assign bus.p1_rdata     = rsp1.rdata;

endmodule
